serial_add_ctrl: RTL and testbench

Bit-serial adder controller that sequences a single one-bit adder resource over `WIDTH` clock cycles to add two `WIDTH`-bit operands. The one-bit resource is a full adder built from two `halfadder_n` cells plus an OR gate. The block provides a start/busy/done handshake and holds its result until the next operation. It is used where area matters more than latency: small front-panel and Arduino-side arithmetic paths.

---
 rtl/serial_add_ctrl.sv | 149 ++++++++++++++
 tb/tb_serial_add_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder controller.
// A single full adder, built from two half-adder stages and an OR, is reused
// once per bit. Operands are captured on start, processed LSB first over WIDTH
// cycles, and the result is held until the next operation is accepted.
// Optional feature macro: SERIAL_ADD_SUB_EN adds the `sub` port (A - B via A + ~B + 1).
module serial_add_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          state_q, state_d;
    logic [WIDTH-1:0] ra_q, ra_d;
    logic [WIDTH-1:0] rb_q, rb_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             accept;
    logic [WIDTH-1:0] b_load;
    logic             cin_load;
    logic             ha0_s, ha0_c, ha1_c, fa_s, fa_c;

    // New operands are taken in IDLE and also in DONE for back-to-back use.
    assign accept = start && ((state_q == StIdle) || (state_q == StDone));

`ifdef SERIAL_ADD_SUB_EN
    // Subtraction folds into the adder as A + ~B + 1.
    assign b_load   = sub ? ~b : b;
    assign cin_load = sub;
`else
    assign b_load   = b;
    assign cin_load = 1'b0;
`endif

    // One-bit full adder from two half-adder stages.
    always_comb begin
        ha0_s = ra_q[0] ^ rb_q[0];
        ha0_c = ra_q[0] & rb_q[0];
        fa_s  = ha0_s ^ carry_q;
        ha1_c = ha0_s & carry_q;
        fa_c  = ha0_c | ha1_c;
    end

    // Next-state logic for the sequencer and datapath shift registers.
    always_comb begin
        state_d = state_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        unique case (state_q)
            StRun: begin
                sum_d   = {fa_s, sum_q[WIDTH-1:1]};
                ra_d    = ra_q >> 1;
                rb_d    = rb_q >> 1;
                carry_d = fa_c;
                cnt_d   = cnt_q + CntW'(1);
                if (cnt_q == LastCnt) begin
                    // carry_q here is the carry into the MSB.
                    cout_d  = fa_c;
                    ovf_d   = carry_q ^ fa_c;
                    cnt_d   = '0;
                    state_d = StDone;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (accept) begin
            ra_d    = a;
            rb_d    = b_load;
            sum_d   = '0;
            cnt_d   = '0;
            carry_d = cin_load;
            state_d = StRun;
            busy_d  = 1'b1;
            done_d  = 1'b0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ra_q    <= '0;
            rb_q    <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign sum       = sum_q;
    assign carry_out = cout_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: directed cases plus randomized
// operations compared against an arithmetic reference model.
`timescale 1ns/1ps
module tb_serial_add_ctrl;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub_s;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         carry_out;
    logic         overflow;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
`ifdef SERIAL_ADD_SUB_EN
        .sub       (sub_s),
`endif
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    // Reference: {overflow, carry_out, sum} from plain integer arithmetic.
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic s);
        longint ux = longint'(x);
        longint uy = longint'(y);
        longint sx = longint'($signed(x));
        longint sy = longint'($signed(y));
        longint smax = (longint'(1) << (W - 1)) - 1;
        longint smin = -(longint'(1) << (W - 1));
        longint ur;
        longint sr;
        logic c;
        logic v;
        logic [W-1:0] r;
        if (s) begin
            ur = ux - uy;
            sr = sx - sy;
            c  = (ux >= uy);
        end else begin
            ur = ux + uy;
            sr = sx + sy;
            c  = (ur >= (longint'(1) << W));
        end
        r = ur[W-1:0];
        v = (sr > smax) || (sr < smin);
        return {v, c, r};
    endfunction

    // Present operands for one cycle, then scramble inputs after capture.
    task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        @(negedge clk);
        a = x; b = y; sub_s = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        sub_s = 1'($urandom_range(1));
    endtask

    // Bounded wait for done; returns on the negedge where done is seen.
    task automatic wait_done(output int busy_n, output int elapsed, output bit both,
                             output bit ok);
        busy_n = 0; elapsed = 0; both = 0; ok = 0;
        for (int i = 0; i < 4 * W + 8; i++) begin
            if (busy && done) both = 1;
            if (done) begin
                ok = 1;
                break;
            end
            if (busy) busy_n++;
            @(negedge clk);
            elapsed++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; sub_s = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy, done, sum, carry_out, overflow} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected all zero",
                     {busy, done, sum, carry_out, overflow});
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy, done, sum, carry_out, overflow} !== '0) begin
            n_fail++;
            $display("FAIL reset_idle_hold: got %b expected all zero",
                     {busy, done, sum, carry_out, overflow});
        end
    endtask

    task automatic test_unsigned_wrap();
        int bn, el; bit both, ok;
        start_op(8'hFF, 8'h01, 1'b0);
        wait_done(bn, el, both, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL wrap_done: got timeout expected done"); end
        n_checks++;
        if (bn != W) begin n_fail++; $display("FAIL wrap_busy_len: got %0d expected %0d", bn, W); end
        n_checks++;
        if (both) begin n_fail++; $display("FAIL wrap_excl: got busy&done expected exclusive"); end
        n_checks++;
        if ({sum, carry_out, overflow} !== {8'h00, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL wrap_result: got %h c=%b v=%b expected 00 c=1 v=0",
                     sum, carry_out, overflow);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_pulse: got done=%b busy=%b expected 0 0", done, busy);
        end
    endtask

    task automatic test_signed_overflow();
        logic [W-1:0] xa [2] = '{8'h7F, 8'h80};
        logic [W-1:0] xb [2] = '{8'h01, 8'h80};
        logic [W+1:0] ex [2] = '{{1'b1, 1'b0, 8'h80}, {1'b1, 1'b1, 8'h00}};
        int bn, el; bit both, ok;
        for (int k = 0; k < 2; k++) begin
            start_op(xa[k], xb[k], 1'b0);
            wait_done(bn, el, both, ok);
            n_checks++;
            if (!ok || {overflow, carry_out, sum} !== ex[k]) begin
                n_fail++;
                $display("FAIL signed_ovf_%0d: got ok=%b v=%b c=%b s=%h expected v,c,s=%b",
                         k, ok, overflow, carry_out, sum, ex[k]);
            end
        end
    endtask

    task automatic test_start_while_busy();
        int bn, el, dones; bit both, ok, changed;
        start_op(8'h23, 8'h11, 1'b0);
        repeat (2) @(negedge clk);
        a = 8'h10; b = 8'h10; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(bn, el, both, ok);
        n_checks++;
        if (!ok || sum !== 8'h34 || carry_out !== 1'b0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_ignore: got ok=%b s=%h c=%b v=%b expected 34 0 0",
                     ok, sum, carry_out, overflow);
        end
        dones = 0; changed = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) dones++;
            if (busy || sum !== 8'h34) changed = 1;
        end
        n_checks++;
        if (dones != 0) begin
            n_fail++;
            $display("FAIL busy_single_done: got %0d extra done expected 0", dones);
        end
        n_checks++;
        if (changed) begin n_fail++; $display("FAIL busy_hold: got change expected hold 34"); end
    endtask

    task automatic test_reset_mid_op();
        int bn, el, dones; bit both, ok;
        start_op(8'h55, 8'h66, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, sum, carry_out, overflow} !== '0) begin
            n_fail++;
            $display("FAIL midrst_clear: got %b expected all zero",
                     {busy, done, sum, carry_out, overflow});
        end
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 2 * W; i++) begin
            @(negedge clk);
            if (done || busy) dones++;
        end
        n_checks++;
        if (dones != 0) begin n_fail++; $display("FAIL midrst_nodone: got %0d expected 0", dones); end
        start_op(8'h05, 8'h0A, 1'b0);
        wait_done(bn, el, both, ok);
        n_checks++;
        if (!ok || sum !== 8'h0F) begin
            n_fail++;
            $display("FAIL midrst_next: got ok=%b s=%h expected 0F", ok, sum);
        end
    endtask

    task automatic test_back_to_back();
        int bn, el; bit both, ok;
        start_op(8'h30, 8'h40, 1'b0);
        wait_done(bn, el, both, ok);
        n_checks++;
        if (!ok || sum !== 8'h70) begin
            n_fail++;
            $display("FAIL b2b_first: got ok=%b s=%h expected 70", ok, sum);
        end
        a = 8'h01; b = 8'h02; sub_s = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(bn, el, both, ok);
        n_checks++;
        if (!ok || el + 1 != W + 1) begin
            n_fail++;
            $display("FAIL b2b_spacing: got %0d cycles expected %0d", el + 1, W + 1);
        end
        n_checks++;
        if (sum !== 8'h03) begin n_fail++; $display("FAIL b2b_sum: got %h expected 03", sum); end
    endtask

`ifdef SERIAL_ADD_SUB_EN
    task automatic test_sub();
        int bn, el; bit both, ok;
        start_op(8'h05, 8'h07, 1'b1);
        wait_done(bn, el, both, ok);
        n_checks++;
        if (!ok || {sum, carry_out, overflow} !== {8'hFE, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL sub_neg: got s=%h c=%b v=%b expected FE 0 0", sum, carry_out, overflow);
        end
        start_op(8'h80, 8'h01, 1'b1);
        wait_done(bn, el, both, ok);
        n_checks++;
        if (!ok || {sum, carry_out, overflow} !== {8'h7F, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL sub_ovf: got s=%h c=%b v=%b expected 7F 1 1", sum, carry_out, overflow);
        end
    endtask
`endif

    task automatic test_random();
        int bn, el; bit both, ok;
        logic [W-1:0] x, y;
        logic s;
        logic [W+1:0] ex;
        for (int i = 0; i < 25; i++) begin
            x = W'($urandom);
            y = W'($urandom);
            s = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
            s = 1'($urandom_range(1));
`endif
            ex = model(x, y, s);
            start_op(x, y, s);
            wait_done(bn, el, both, ok);
            n_checks++;
            if (!ok || bn != W || both || {overflow, carry_out, sum} !== ex) begin
                n_fail++;
                $display("FAIL rand_%0d: a=%h b=%h s=%b got ok=%b busy=%0d v,c,s=%b expected %b",
                         i, x, y, s, ok, bn, {overflow, carry_out, sum}, ex);
            end
        end
    endtask

    initial begin
        test_reset();
        test_unsigned_wrap();
        test_signed_overflow();
        test_start_while_busy();
        test_reset_mid_op();
        test_back_to_back();
`ifdef SERIAL_ADD_SUB_EN
        test_sub();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
